// File: rtl/fetch_queue.sv
// fetch_queue: prefetching fetch stage. Issues word reads over req/ack and buffers
// {ins, PC+4} pairs in a DEPTH-entry FIFO drained by decode; redirects flush and refetch.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTRW  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     entryPoint,
    input  logic            redirect,
    input  logic [31:0]     redirectPC,
    output logic            imem_req,
    output logic [31:0]     imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic [31:0]     ins,
    output logic [31:0]     PCp4,
    output logic            ins_valid,
    input  logic            ins_ready,
    output logic [PTRW:0]   count
);
    typedef enum logic {FETCH, DISCARD} state_e;

    localparam logic [PTRW:0] FULL_CNT = (PTRW+1)'(DEPTH);

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     target_q, target_d;
    logic [PTRW-1:0] head_q, head_d;
    logic [PTRW-1:0] tail_q, tail_d;
    logic [PTRW:0]   count_q, count_d;
    logic [31:0]     ins_mem  [DEPTH];
    logic [31:0]     pcp4_mem [DEPTH];
    logic            req_int;
    logic            push;
    logic            pop;
    logic [31:0]     pc_inc;

    assign pc_inc  = pc_q + 32'd4;
    // Request is a function of registered state only, so it never loops through imem_ack.
    assign req_int = (state_q == DISCARD) || (count_q < FULL_CNT);

    always_ff @(posedge clk) begin
        state_q  <= state_d;
        pc_q     <= pc_d;
        target_q <= target_d;
        head_q   <= head_d;
        tail_q   <= tail_d;
        count_q  <= count_d;
        if (push) begin
            ins_mem[tail_q]  <= imem_data;
            pcp4_mem[tail_q] <= pc_inc;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        push     = 1'b0;
        pop      = 1'b0;
        if (reset) begin
            state_d = FETCH;
            pc_d    = entryPoint & ~32'd3;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            // A read still in flight must be drained before the new target is issued.
            if (req_int && !imem_ack) begin
                state_d  = DISCARD;
                target_d = redirectPC & ~32'd3;
            end else begin
                state_d = FETCH;
                pc_d    = redirectPC & ~32'd3;
            end
        end else if (state_q == DISCARD) begin
            if (imem_ack) begin
                state_d = FETCH;
                pc_d    = target_q;
            end
        end else begin
            pop  = (count_q != '0) && ins_ready;
            push = req_int && imem_ack;
            if (push) begin
                pc_d   = pc_inc;
                tail_d = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        imem_req  = !reset && req_int;
        imem_addr = pc_q;
        ins_valid = !reset && (count_q != '0);
        count     = reset ? '0 : count_q;
        ins       = '0;
        PCp4      = '0;
        if (ins_valid) begin
            ins  = ins_mem[head_q];
            PCp4 = pcp4_mem[head_q];
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios with literal expectations plus randomized
// traffic, all compared every cycle against a queue-based model of the fetch stage.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [31:0] entryPoint;
    logic        redirect;
    logic [31:0] redirectPC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] ins;
    logic [31:0] PCp4;
    logic        ins_valid;
    logic        ins_ready;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0FFEE11;
    endfunction

    assign imem_data = mem_word(imem_addr);

    fetch_queue #(.DEPTH(4), .PTRW(2)) dut (
        .clk(clk), .reset(reset), .entryPoint(entryPoint),
        .redirect(redirect), .redirectPC(redirectPC),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .ins(ins), .PCp4(PCp4), .ins_valid(ins_valid),
        .ins_ready(ins_ready), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: fetch PC, pending-discard flag and target, queue of fetched pairs.
    bit          model_ok = 1'b0;
    bit          m_disc;
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    logic [31:0] mq_ins[$];
    logic [31:0] mq_pc[$];

    initial forever begin
        bit m_req;
        @(posedge clk);
        m_req = m_disc || (mq_ins.size() < DEPTH);
        if (reset) begin
            m_pc = entryPoint & ~32'd3;
            m_disc = 1'b0;
            mq_ins.delete();
            mq_pc.delete();
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (redirect) begin
                mq_ins.delete();
                mq_pc.delete();
                if (m_req && !imem_ack) begin
                    m_disc = 1'b1;
                    m_tgt = redirectPC & ~32'd3;
                end else begin
                    m_disc = 1'b0;
                    m_pc = redirectPC & ~32'd3;
                end
            end else if (m_disc) begin
                if (imem_ack) begin
                    m_disc = 1'b0;
                    m_pc = m_tgt;
                end
            end else begin
                if (mq_ins.size() > 0 && ins_ready) begin
                    void'(mq_ins.pop_front());
                    void'(mq_pc.pop_front());
                end
                if (m_req && imem_ack) begin
                    mq_ins.push_back(mem_word(m_pc));
                    mq_pc.push_back(m_pc + 32'd4);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // Compare process: every cycle once the model has seen a reset.
    initial forever begin
        int e_cnt;
        @(negedge clk);
        if (model_ok) begin
            e_cnt = reset ? 0 : mq_ins.size();
            chk("m_req", {31'b0, imem_req},
                {31'b0, !reset && (m_disc || mq_ins.size() < DEPTH)});
            chk("m_count", {29'b0, count}, e_cnt);
            chk("m_valid", {31'b0, ins_valid}, {31'b0, e_cnt != 0});
            chk("m_ins", ins, (e_cnt != 0) ? mq_ins[0] : 32'd0);
            chk("m_pcp4", PCp4, (e_cnt != 0) ? mq_pc[0] : 32'd0);
            if (!reset) chk("m_addr", imem_addr, m_pc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [31:0] ep);
        reset = 1'b1;
        entryPoint = ep;
        redirect = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        entryPoint = $urandom;
    endtask

    initial begin
        int rdy_pct;
        reset = 1'b1; entryPoint = 32'd128; redirect = 1'b0; redirectPC = '0;
        imem_ack = 1'b1; ins_ready = 1'b1;

        // 1: streaming from entryPoint with ack tied high
        tick();
        neg();
        chk("rst_req", {31'b0, imem_req}, 0);
        chk("rst_count", {29'b0, count}, 0);
        chk("rst_valid", {31'b0, ins_valid}, 0);
        tick();
        reset = 1'b0;
        neg();
        chk("s1_addr0", imem_addr, 32'd128);
        chk("s1_req0", {31'b0, imem_req}, 1);
        tick(); neg();
        chk("s1_addr1", imem_addr, 32'd132);
        chk("s1_pcp4_1", PCp4, 32'd132);
        chk("s1_ins1", ins, mem_word(32'd128));
        tick(); neg();
        chk("s1_addr2", imem_addr, 32'd136);
        chk("s1_pcp4_2", PCp4, 32'd136);
        chk("s1_count2", {29'b0, count}, 1);

        // 2: fill with ready low, then a single pop
        ins_ready = 1'b0; imem_ack = 1'b1;
        do_reset(32'd128);
        repeat (4) tick();
        neg();
        chk("s2_full_count", {29'b0, count}, 4);
        chk("s2_full_req", {31'b0, imem_req}, 0);
        chk("s2_full_addr", imem_addr, 32'd144);
        chk("s2_head_pcp4", PCp4, 32'd132);
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        neg();
        chk("s2_pop_count", {29'b0, count}, 3);
        chk("s2_resume_req", {31'b0, imem_req}, 1);
        chk("s2_resume_addr", imem_addr, 32'd144);

        // 3: ack delayed three cycles
        ins_ready = 1'b1; imem_ack = 1'b0;
        do_reset(32'h40);
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("s3_wait_req", {31'b0, imem_req}, 1);
            chk("s3_wait_addr", imem_addr, 32'h40);
            tick();
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        neg();
        chk("s3_count", {29'b0, count}, 1);
        chk("s3_pcp4", PCp4, 32'h44);
        chk("s3_addr", imem_addr, 32'h44);
        tick(); neg();
        chk("s3_once", {29'b0, count}, 0);

        // 4: redirect with a read outstanding
        ins_ready = 1'b1; imem_ack = 1'b0;
        do_reset(32'h88);
        neg();
        chk("s4_addr", imem_addr, 32'h88);
        redirect = 1'b1; redirectPC = 32'h200;
        tick();
        redirect = 1'b0; redirectPC = $urandom;
        neg();
        chk("s4_hold_addr", imem_addr, 32'h88);
        chk("s4_hold_req", {31'b0, imem_req}, 1);
        chk("s4_flush_count", {29'b0, count}, 0);
        tick();
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        neg();
        chk("s4_new_addr", imem_addr, 32'h200);
        chk("s4_dropped", {29'b0, count}, 0);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        neg();
        chk("s4_first_pcp4", PCp4, 32'h204);
        chk("s4_first_ins", ins, mem_word(32'h200));

        // 5: redirect and ack in the same cycle with two entries queued
        ins_ready = 1'b0; imem_ack = 1'b1;
        do_reset(32'h300);
        tick(); tick();
        neg();
        chk("s5_pre_count", {29'b0, count}, 2);
        redirect = 1'b1; redirectPC = 32'h403; ins_ready = 1'b1;
        tick();
        redirect = 1'b0; imem_ack = 1'b0; ins_ready = 1'b0;
        neg();
        chk("s5_count", {29'b0, count}, 0);
        chk("s5_valid", {31'b0, ins_valid}, 0);
        chk("s5_addr", imem_addr, 32'h400);

        // 6: address wrap, then reset while stalled full
        ins_ready = 1'b0; imem_ack = 1'b1;
        do_reset(32'hFFFF_FFFF);
        tick(); neg();
        chk("s6_wrap_pcp4", PCp4, 32'd0);
        chk("s6_wrap_addr", imem_addr, 32'd0);
        tick(); tick(); tick(); neg();
        chk("s6_stall_req", {31'b0, imem_req}, 0);
        reset = 1'b1; entryPoint = 32'h1000;
        neg();
        chk("s6_rst_req", {31'b0, imem_req}, 0);
        chk("s6_rst_count", {29'b0, count}, 0);
        chk("s6_rst_valid", {31'b0, ins_valid}, 0);
        tick();
        reset = 1'b0;
        neg();
        chk("s6_entry_addr", imem_addr, 32'h1000);

        // Randomized traffic
        rdy_pct = 60;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) rdy_pct = $urandom_range(5, 95);
            reset      = ($urandom_range(0, 299) == 0);
            entryPoint = $urandom;
            redirect   = ($urandom_range(0, 15) == 0);
            redirectPC = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : $urandom;
            imem_ack   = ($urandom_range(0, 99) < 60);
            ins_ready  = ($urandom_range(0, 99) < rdy_pct);
            tick();
        end
        reset = 1'b0; redirect = 1'b0; imem_ack = 1'b0; ins_ready = 1'b0;
        tick(); neg();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
